// File: rtl/mul64_acc.sv
`default_nettype none
// mul64_acc: sums TERMS 64-bit products (delivered as 32-bit halves) with a
// two-stage split-carry adder, then offers the sum on a valid/ready port.
module mul64_acc #(
   parameter int unsigned TERMS = 4,
   parameter int unsigned CW    = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_lo,
   input  logic [31:0] in_hi,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_lo,
   output logic [31:0] out_hi,
   output logic        out_ovf
);

   typedef enum logic [1:0] {
      ACC   = 2'd0,
      DRAIN = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t          state_q;
   logic            in_ready_q;
   logic            out_valid_q;
   logic [31:0]     acc_lo_q;
   logic [31:0]     acc_hi_q;
   logic [31:0]     pend_hi_q;
   logic            pend_c_q;
   logic            pend_valid_q;
   logic            ovf_q;
   logic [CW-1:0]   count_q;

   logic            accept_d;
   logic            take_d;
   logic            last_d;
   logic [CW-1:0]   count_d;
   logic [32:0]     sum_lo_d;
   logic [32:0]     sum_hi_d;

   assign accept_d = in_valid & in_ready_q;
   assign take_d   = out_valid_q & out_ready;
   assign count_d  = count_q + 1'b1;
   assign last_d   = (count_d == CW'(TERMS));
   assign sum_lo_d = {1'b0, acc_lo_q} + {1'b0, in_lo};
   assign sum_hi_d = {1'b0, acc_hi_q} + {1'b0, pend_hi_q} + {32'd0, pend_c_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ACC;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ACC: begin
               if (accept_d && last_d) begin
                  state_q    <= DRAIN;
                  in_ready_q <= 1'b0;
               end
            end
            DRAIN: begin
               state_q     <= HOLD;
               out_valid_q <= 1'b1;
            end
            HOLD: begin
               if (out_ready) begin
                  state_q     <= ACC;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= ACC;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Low half and high half live in separate registers, so stage 1 of a new
   // term and stage 2 of the previous one can update on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_lo_q     <= '0;
         acc_hi_q     <= '0;
         pend_hi_q    <= '0;
         pend_c_q     <= 1'b0;
         pend_valid_q <= 1'b0;
         ovf_q        <= 1'b0;
         count_q      <= '0;
      end else begin
         if (take_d) begin
            acc_lo_q <= '0;
            count_q  <= '0;
         end else if (accept_d) begin
            acc_lo_q <= sum_lo_d[31:0];
            count_q  <= count_d;
         end

         if (accept_d) begin
            pend_hi_q    <= in_hi;
            pend_c_q     <= sum_lo_d[32];
            pend_valid_q <= 1'b1;
         end else begin
            pend_valid_q <= 1'b0;
         end

         if (take_d) begin
            acc_hi_q <= '0;
            ovf_q    <= 1'b0;
         end else if (pend_valid_q) begin
            acc_hi_q <= sum_hi_d[31:0];
            if (sum_hi_d[32]) ovf_q <= 1'b1;
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_lo    = acc_lo_q;
   assign out_hi    = acc_hi_q;
   assign out_ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_mul64_acc.sv
`default_nettype none
// tb_mul64_acc: scoreboard bench for mul64_acc (TERMS=4) plus a TERMS=1 instance.
module tb_mul64_acc;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_lo = '0;
   logic [31:0] in_hi = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_lo;
   logic [31:0] out_hi;
   logic        out_ovf;

   logic        in_valid1 = 1'b0;
   logic        in_ready1;
   logic [31:0] in_lo1 = '0;
   logic [31:0] in_hi1 = '0;
   logic        out_valid1;
   logic        out_ready1 = 1'b1;
   logic [31:0] out_lo1;
   logic [31:0] out_hi1;
   logic        out_ovf1;

   int n_checks = 0;
   int n_errors = 0;

   logic [64:0] sb_q[$];
   logic [63:0] m_sum;
   logic        m_ovf;
   int          m_cnt;

   always #5 clk = ~clk;

   mul64_acc #(.TERMS(4), .CW(8)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_lo(in_lo), .in_hi(in_hi),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_lo(out_lo), .out_hi(out_hi), .out_ovf(out_ovf)
   );

   mul64_acc #(.TERMS(1), .CW(2)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid1), .in_ready(in_ready1), .in_lo(in_lo1), .in_hi(in_hi1),
      .out_valid(out_valid1), .out_ready(out_ready1),
      .out_lo(out_lo1), .out_hi(out_hi1), .out_ovf(out_ovf1)
   );

   task automatic check(input string tag, input logic [64:0] act, input logic [64:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic model_clear();
      m_sum = '0;
      m_ovf = 1'b0;
      m_cnt = 0;
   endtask

   task automatic model_accept(input logic [31:0] lo, input logic [31:0] hi);
      logic [64:0] s;
      s = {1'b0, m_sum} + {1'b0, hi, lo};
      m_sum = s[63:0];
      m_ovf = m_ovf | s[64];
      m_cnt++;
      if (m_cnt == 4) begin
         sb_q.push_back({m_ovf, m_sum});
         model_clear();
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic [31:0] lo, input logic [31:0] hi);
      int budget;
      in_valid = 1'b1;
      in_lo    = lo;
      in_hi    = hi;
      budget   = 0;
      while (!in_ready && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      if (!in_ready) begin
         check("send_timeout", 65'd1, 65'd0);
      end else begin
         @(posedge clk);
         model_accept(lo, hi);
         @(negedge clk);
      end
   endtask

   task automatic idle();
      in_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_drain();
      int budget;
      budget = 0;
      while (sb_q.size() != 0 && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      check("drain", 65'(sb_q.size()), 65'd0);
   endtask

   // Handshake happens on the next rising edge when both are high here.
   initial begin
      logic [64:0] exp;
      forever begin
         @(negedge clk);
         #1;
         if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               check("unexpected_result", 65'd1, 65'd0);
            end else begin
               exp = sb_q.pop_front();
               check("result", {out_ovf, out_hi, out_lo}, exp);
            end
         end
      end
   end

   initial begin
      model_clear();
      #12;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 65'(in_ready), 65'd1);
      check("rst_out_valid", 65'(out_valid), 65'd0);

      // Back-to-back accumulation and ready/valid timing
      for (int i = 0; i < 4; i++) send(32'd12, 32'd0);
      in_valid = 1'b0;
      check("t1_drain_rdy", 65'(in_ready), 65'd0);
      check("t1_drain_vld", 65'(out_valid), 65'd0);
      @(negedge clk);
      check("t1_hold_rdy", 65'(in_ready), 65'd0);
      check("t1_hold_vld", 65'(out_valid), 65'd1);
      @(negedge clk);
      check("t1_back_rdy", 65'(in_ready), 65'd1);
      check("t1_back_vld", 65'(out_valid), 65'd0);

      // Carry between halves
      send(32'hFFFF_FFFF, 32'd0);
      send(32'hFFFF_FFFF, 32'd0);
      send(32'd1, 32'd0);
      send(32'd0, 32'd0);
      idle();
      wait_drain();

      // Overflow out of bit 63, then flag cleared for the next result
      send(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      send(32'd1, 32'd0);
      send(32'd0, 32'd0);
      send(32'd0, 32'd0);
      for (int i = 0; i < 4; i++) send(32'd1, 32'd0);
      idle();
      wait_drain();

      // Back-pressure with a waiting producer
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(32'd3, 32'd0);
      in_valid = 1'b1;
      in_lo    = 32'd7;
      in_hi    = 32'd0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_vld", 65'(out_valid), 65'd1);
         check("bp_out", {out_ovf, out_hi, out_lo}, {1'b0, 32'd0, 32'd12});
         check("bp_rdy", 65'(in_ready), 65'd0);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) send(32'd7, 32'd0);
      idle();
      wait_drain();

      // Asynchronous reset in the middle of a sum
      send(32'd100, 32'd0);
      send(32'd100, 32'd0);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_rdy", 65'(in_ready), 65'd1);
      check("ar_vld", 65'(out_valid), 65'd0);
      check("ar_out", {out_ovf, out_hi, out_lo}, 65'd0);
      model_clear();
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) send(32'd1, 32'd1);
      idle();
      wait_drain();

      // Gapped input
      for (int i = 0; i < 4; i++) begin
         send(32'h8000_0000, 32'd2);
         idle();
      end
      wait_drain();

      // TERMS=1 instance: result one cycle after the accept
      in_valid1 = 1'b1;
      in_lo1    = 32'd5;
      in_hi1    = 32'd6;
      check("t1x_rdy", 65'(in_ready1), 65'd1);
      @(negedge clk);
      in_valid1 = 1'b0;
      check("t1x_drain_vld", 65'(out_valid1), 65'd0);
      check("t1x_drain_rdy", 65'(in_ready1), 65'd0);
      @(negedge clk);
      check("t1x_hold_vld", 65'(out_valid1), 65'd1);
      check("t1x_out", {out_ovf1, out_hi1, out_lo1}, {1'b0, 32'd6, 32'd5});
      @(negedge clk);
      check("t1x_back_rdy", 65'(in_ready1), 65'd1);

      repeat (3) @(negedge clk);
      check("sb_empty", 65'(sb_q.size()), 65'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      check("global_timeout", 65'd1, 65'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
